fab_uart_rx: RTL and testbench
==============================

Name: fab_uart_rx

Overview:
- Fabric-side UART receiver that listens to the MSS MMUART_0_TXD line.
- Recovers 8N1 frames, or 8E1/8O1 frames when parity is compiled in, using 16x oversampling.
- Buffers received bytes in a small FIFO with a valid/ready output and sticky error flags.
- Sits in the fabric, clocked by the CCC GL0 clock, as the far end of the MSS UART transmitter.

Parameters:
- BAUD_DIV, 27, CLK_BASE cycles per 16x oversample tick (50 MHz / (16*115200) ≈ 27); legal 1..65535.
- FIFO_DEPTH, 4, receive FIFO entries; power of 2, minimum 2.
- PARITY_ODD, 0, parity sense when PARITY_CHECK_EN is defined: 0 = even, 1 = odd.

Ports:
- CLK_BASE  in  1  fabric clock (CCC GL0).
- FAB_RESET  in  1  asynchronous, active-high reset.
- RXD  in  1  serial input, idle high, asynchronous to CLK_BASE.
- RX_DATA  out  8  FIFO head byte.
- RX_VALID  out  1  FIFO not empty.
- RX_READY  in  1  consumer accepts head when RX_VALID=1.
- RX_BUSY  out  1  a frame is in progress (state != IDLE).
- FRAMING_ERR  out  1  sticky: stop bit sampled 0.
- OVERRUN  out  1  sticky: byte dropped because the FIFO was full.
- PARITY_ERR  out  1  sticky parity mismatch; tied 0 without PARITY_CHECK_EN.
- ERR_CLR  in  1  single-cycle clear of all sticky flags.

Behaviour:
- Reset state, applied asynchronously on FAB_RESET=1:
  - sync flops = 1, state = IDLE, tick/sample counters = 0, FIFO empty.
  - RX_VALID=0, RX_DATA=0, RX_BUSY=0, all error flags = 0.
- Reset mid-frame aborts the frame. The partial byte is discarded; nothing is written to the FIFO.
- Input sync: RXD passes through a 2-flop synchronizer (rxd_s). All decisions use rxd_s.
- Tick generator: counts 0..BAUD_DIV-1 and pulses tick when count==BAUD_DIV-1.
  - Free-running; reset only by FAB_RESET.
  - With BAUD_DIV=1, tick is asserted every cycle.
- 4-bit sample counter advances on tick. It is cleared on each state entry.
- FSM states and transitions:
  - IDLE: rxd_s==0 → START, clearing the sample counter.
  - START: at the 8th tick (mid-bit) sample rxd_s. If 1 → IDLE (glitch rejected, no flag). If 0 → DATA, bit index 0.
  - DATA: every 16th tick sample rxd_s and shift it in LSB-first. After bit 7 → PARITY if the macro is defined, else → STOP.
  - PARITY: on the 16th tick, compare the sampled bit with the computed parity; mismatch sets PARITY_ERR, then → STOP.
  - STOP, on the 16th tick:
    - rxd_s==1: push the byte (parity-errored bytes are still pushed), → IDLE.
    - rxd_s==0: set FRAMING_ERR, discard the byte, → BREAK.
  - BREAK: wait for rxd_s==1, then → IDLE. A held-low line or break produces exactly one FRAMING_ERR.
- Stop handling: return to IDLE at the stop-bit midpoint, so back-to-back frames with no idle gap are received.
- Latency: the byte is visible on RX_VALID/RX_DATA the cycle after the stop-bit sample.
- FIFO:
  - RX_DATA always shows the head entry. Pop occurs when RX_VALID && RX_READY.
  - A push is accepted when the FIFO is not full, or when it is full and a pop happens in the same cycle.
  - Otherwise the byte is dropped and OVERRUN is set.
  - Push into an empty FIFO: RX_VALID rises the next cycle.
  - Pointers wrap modulo FIFO_DEPTH; an extra occupancy bit distinguishes full from empty.
- Sticky flags: cleared by ERR_CLR. If a set event and ERR_CLR occur in the same cycle, the flag is 1 after that cycle (set wins). ERR_CLR does not affect the FIFO.

Optional Feature:
- Macro PARITY_CHECK_EN.
- Defined: PARITY state is present and the frame is 8 data + parity + stop. PARITY_ERR is active with sense set by PARITY_ODD.
- Undefined: 8N1 framing, no PARITY state, PARITY_ERR tied 0, PARITY_ODD ignored.

Test Plan:
- BAUD_DIV=4 (64 clocks/bit), send 0xA5 8N1 → RX_VALID high 1 cycle after the stop midpoint, RX_DATA=0xA5, no flags.
- 20-clock low pulse on an idle line → FSM returns to IDLE at the START mid-sample; no push, no flags.
- FIFO_DEPTH=4, RX_READY=0, send 0x01..0x05 back-to-back → 4 bytes held, OVERRUN=1, pops return 0x01..0x04. Then ERR_CLR → OVERRUN=0.
- Send 0x3C with stop bit 0, then hold RXD low 5 bit-times → FRAMING_ERR=1 once, FIFO empty. After RXD goes high, 0x3C with a valid stop is received.
- With PARITY_CHECK_EN and PARITY_ODD=0, send 0x07 with parity bit 0 → PARITY_ERR=1, RX_DATA=0x07 pushed. Then send 0x07 with parity 1 → no new error.
- Assert FAB_RESET mid-DATA of 0xFF → outputs return to reset values immediately. After release, 0x5A is received correctly.

Source files
------------

// File: rtl/fab_uart_rx.sv
// fab_uart_rx: 16x-oversampled UART receiver with a valid/ready FIFO and sticky error flags.
// Define PARITY_CHECK_EN for 8E1/8O1 framing (sense from PARITY_ODD); default is 8N1.
module fab_uart_rx #(
  parameter int BAUD_DIV   = 27,
  parameter int FIFO_DEPTH = 4,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       CLK_BASE,
  input  logic       FAB_RESET,
  input  logic       RXD,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  input  logic       RX_READY,
  output logic       RX_BUSY,
  output logic       FRAMING_ERR,
  output logic       OVERRUN,
  output logic       PARITY_ERR,
  input  logic       ERR_CLR
);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef PARITY_CHECK_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif
  state_t state, state_n;
  logic rxd_m, rxd_s, tick, mid, bit_end;
  logic clr, shift, push, fe_set, pop, full, wr;
  logic [15:0] tcnt;
  logic [3:0] scnt;
  logic [2:0] bidx;
  logic [7:0] shreg;
  logic [AW:0] wp, rp;
  logic [7:0] mem [FIFO_DEPTH];
  assign tick = tcnt == 16'(BAUD_DIV - 1);
  assign mid = tick && scnt == 4'd7;
  assign bit_end = tick && scnt == 4'd15;
  assign RX_BUSY = state != IDLE;
  assign RX_VALID = wp != rp;
  assign RX_DATA = mem[rp[AW-1:0]];
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop = RX_VALID && RX_READY;
  assign wr = push && (!full || pop);
`ifdef PARITY_CHECK_EN
  logic pe_set;
`endif
  always_comb begin
    state_n = state;
    shift = 1'b0;
    push = 1'b0;
    fe_set = 1'b0;
`ifdef PARITY_CHECK_EN
    pe_set = 1'b0;
`endif
    case (state)
      IDLE:  state_n = rxd_s ? IDLE : START;
      START: if (mid) state_n = rxd_s ? IDLE : DATA;
      DATA: if (bit_end) begin
        shift = 1'b1;
`ifdef PARITY_CHECK_EN
        if (bidx == 3'd7) state_n = PARITY;
`else
        if (bidx == 3'd7) state_n = STOP;
`endif
      end
`ifdef PARITY_CHECK_EN
      PARITY: if (bit_end) begin
        pe_set = rxd_s != (^shreg ^ PARITY_ODD);
        state_n = STOP;
      end
`endif
      STOP: if (bit_end) begin
        push = rxd_s;
        fe_set = !rxd_s;
        state_n = rxd_s ? IDLE : BREAK;
      end
      BREAK:   state_n = rxd_s ? IDLE : BREAK;
      default: state_n = IDLE;
    endcase
  end
  // any state change restarts the oversample count for the new bit
  assign clr = state_n != state;
  always_ff @(posedge CLK_BASE or posedge FAB_RESET)
    if (FAB_RESET) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge CLK_BASE or posedge FAB_RESET) begin
    if (FAB_RESET) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      tcnt <= '0;
      scnt <= '0;
      bidx <= '0;
      shreg <= '0;
      FRAMING_ERR <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      rxd_m <= RXD;
      rxd_s <= rxd_m;
      tcnt <= tick ? '0 : tcnt + 16'd1;
      scnt <= clr ? 4'd0 : tick ? scnt + 4'd1 : scnt;
      if (clr && state_n == DATA) bidx <= '0;
      else if (shift) bidx <= bidx + 3'd1;
      if (shift) shreg <= {rxd_s, shreg[7:1]};
      FRAMING_ERR <= fe_set || (FRAMING_ERR && !ERR_CLR);
      OVERRUN <= (push && !wr) || (OVERRUN && !ERR_CLR);
    end
  end
`ifdef PARITY_CHECK_EN
  always_ff @(posedge CLK_BASE or posedge FAB_RESET)
    if (FAB_RESET) PARITY_ERR <= 1'b0;
    else PARITY_ERR <= pe_set || (PARITY_ERR && !ERR_CLR);
`else
  assign PARITY_ERR = 1'b0;
`endif
  always_ff @(posedge CLK_BASE or posedge FAB_RESET) begin
    if (FAB_RESET) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wp[AW-1:0]] <= shreg;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
    end
  end
endmodule

// File: tb/tb_fab_uart_rx.sv
// tb_fab_uart_rx: directed checks of fab_uart_rx at BAUD_DIV=4 (64 clocks per bit), FIFO_DEPTH=4.
module tb_fab_uart_rx;
`ifdef PARITY_CHECK_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk = 1'b0, rst = 1'b1, rxd = 1'b1, ready = 1'b0, err_clr = 1'b0;
  logic [7:0] data;
  logic valid, busy, fe, ov, pe;
  int errors = 0, checks = 0, vseen;
  fab_uart_rx #(.BAUD_DIV(4), .FIFO_DEPTH(4), .PARITY_ODD(1'b0)) dut (
    .CLK_BASE(clk), .FAB_RESET(rst), .RXD(rxd), .RX_DATA(data), .RX_VALID(valid),
    .RX_READY(ready), .RX_BUSY(busy), .FRAMING_ERR(fe), .OVERRUN(ov),
    .PARITY_ERR(pe), .ERR_CLR(err_clr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  // drives one frame LSB-first; vseen = clocks from start edge to first RX_VALID rise
  task automatic send(input logic [7:0] b, input logic par, input logic stop_bit);
    logic [10:0] fr;
    logic v0;
`ifdef PARITY_CHECK_EN
    fr = {stop_bit, par, b, 1'b0};
`else
    fr = {1'b1, stop_bit, b, 1'b0};
    if (par) fr[10] = 1'b1;
`endif
    v0 = valid;
    vseen = -1;
    for (int n = 0; n < NB * 64; n++) begin
      @(negedge clk);
      if (n > 0 && vseen < 0 && !v0 && valid) vseen = n;
      rxd = fr[n / 64];
    end
  endtask
  task automatic pop1;
    @(negedge clk) ready = 1'b1;
    @(negedge clk) ready = 1'b0;
  endtask
  task automatic clear_errs;
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
  endtask
  initial begin
    idle(3);
    chk("rst_valid", valid, 1'b0);
    chk("rst_data", data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_flags", {fe, ov, pe}, 3'b000);
    @(negedge clk) rst = 1'b0;
    idle(10);
    send(8'hA5, 1'b0, 1'b1);
    chk("a5_latency", vseen >= NB * 64 - 34 && vseen <= NB * 64 - 26, 1'b1);
    chk("a5_data", data, 8'hA5);
    chk("a5_flags", {fe, ov, pe}, 3'b000);
    pop1;
    chk("a5_popped", valid, 1'b0);
    idle(64);
    rxd = 1'b0;
    idle(10);
    chk("glitch_busy", busy, 1'b1);
    idle(10);
    rxd = 1'b1;
    idle(40);
    chk("glitch_idle", busy, 1'b0);
    chk("glitch_nopush", valid, 1'b0);
    chk("glitch_flags", {fe, ov, pe}, 3'b000);
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b0, 1'b1);
    idle(64);
    chk("ov_set", ov, 1'b1);
    chk("ov_fe", fe, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ov_pop%0d", i), {valid, data}, {1'b1, 8'(i)});
      pop1;
    end
    chk("ov_empty", valid, 1'b0);
    clear_errs;
    chk("ov_clr", ov, 1'b0);
`ifdef PARITY_CHECK_EN
    send(8'h07, 1'b0, 1'b1);
    idle(64);
    chk("par_bad_pe", pe, 1'b1);
    chk("par_bad_data", {valid, data}, {1'b1, 8'h07});
    pop1;
    clear_errs;
    send(8'h07, 1'b1, 1'b1);
    idle(64);
    chk("par_good_pe", pe, 1'b0);
    chk("par_good_data", {valid, data}, {1'b1, 8'h07});
    pop1;
`endif
    send(8'h3C, 1'b0, 1'b0);
    idle(160);
    chk("fe_set", fe, 1'b1);
    chk("fe_nopush", valid, 1'b0);
    chk("fe_break_busy", busy, 1'b1);
    clear_errs;
    idle(160);
    chk("fe_once", fe, 1'b0);
    rxd = 1'b1;
    idle(64);
    chk("fe_idle", busy, 1'b0);
    send(8'h3C, 1'b0, 1'b1);
    idle(64);
    chk("fe_recover", {valid, data}, {1'b1, 8'h3C});
    chk("fe_recover_fe", fe, 1'b0);
    chk("pe_tied", pe, 1'b0);
    rxd = 1'b0;
    idle(64);
    rxd = 1'b1;
    idle(150);
    chk("mid_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_valid", valid, 1'b0);
    chk("arst_data", data, 8'h00);
    idle(3);
    rst = 1'b0;
    idle(64 * 8);
    chk("arst_nopush", valid, 1'b0);
    send(8'h5A, 1'b0, 1'b1);
    idle(64);
    chk("after_rst_data", {valid, data}, {1'b1, 8'h5A});
    chk("after_rst_flags", {fe, ov, pe}, 3'b000);
    pop1;
    chk("after_rst_single", valid, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
